// File: rtl/rf_dbg_ctrl.sv
// Register-file write-port arbiter and UART register-dump sequencer.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the dump.
module rf_dbg_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk_o,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              dbg_wr_req,
    input  logic [ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_wr_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              pipe_stall,
    output logic [ADDR_W-1:0] dump_raddr,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);
    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ,
        SEND,
`ifdef DUMP_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         drain_cnt, drain_cnt_n;
    logic [ADDR_W-1:0]     idx, idx_n;
    logic [BW-1:0]         bidx, bidx_n;
    logic [NB-1:0][7:0]    word, word_n;
    logic [7:0]            tx_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            cksum, cksum_n;
`endif

    // MSB byte goes out first
    assign tx_byte = word[BW'(NB-1) - bidx];

    always_ff @(posedge clk_o) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            idx       <= '0;
            bidx      <= '0;
            word      <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            idx       <= idx_n;
            bidx      <= bidx_n;
            word      <= word_n;
`ifdef DUMP_CHECKSUM_EN
            cksum     <= cksum_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        idx_n       = idx;
        bidx_n      = bidx;
        word_n      = word;
`ifdef DUMP_CHECKSUM_EN
        cksum_n     = cksum;
`endif
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                    idx_n       = '0;
                    bidx_n      = '0;
`ifdef DUMP_CHECKSUM_EN
                    cksum_n     = '0;
`endif
                end
            end
            DRAIN: begin
                if (drain_cnt == CW'(DRAIN_CYCLES - 1))
                    state_n = READ;
                else
                    drain_cnt_n = drain_cnt + 1'b1;
            end
            READ: begin
                word_n  = (idx == '0) ? '0 : rf_rdata1;
                bidx_n  = '0;
                state_n = SEND;
            end
            SEND: begin
                if (tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    cksum_n = cksum ^ tx_byte;
`endif
                    if (bidx == BW'(NB - 1)) begin
                        bidx_n = '0;
                        if (idx == ADDR_W'(NUM_REGS - 1)) begin
`ifdef DUMP_CHECKSUM_EN
                            state_n = CKSUM;
`else
                            state_n = DONE;
`endif
                        end else begin
                            idx_n   = idx + 1'b1;
                            state_n = READ;
                        end
                    end else begin
                        bidx_n = bidx + 1'b1;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM: begin
                if (tx_ready)
                    state_n = DONE;
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Writeback always wins; debug writes only slip in while idle
    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        dbg_wr_ack = 1'b0;
        if (!rst) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (dbg_wr_req && state == IDLE) begin
                dbg_wr_ack = 1'b1;
                rf_we      = (dbg_waddr != '0);
                rf_waddr   = dbg_waddr;
                rf_wdata   = dbg_wdata;
            end
        end
    end

    always_comb begin
        dump_busy  = (state != IDLE);
        pipe_stall = (state != IDLE);
        dump_done  = (state == DONE);
        dump_raddr = (state == READ) ? idx : '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        if (state == SEND) begin
            tx_valid = 1'b1;
            tx_data  = tx_byte;
        end
`ifdef DUMP_CHECKSUM_EN
        if (state == CKSUM) begin
            tx_valid = 1'b1;
            tx_data  = cksum;
        end
`endif
    end

endmodule

// File: tb/tb_rf_dbg_ctrl.sv
// Randomized bench for rf_dbg_ctrl against a byte-stream and arbitration model.
`timescale 1ns/1ps
module tb_rf_dbg_ctrl;
    localparam int N     = 32;
    localparam int NB    = 4;
    localparam int DRAIN = 2;
`ifdef DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk_o = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        dbg_wr_req;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        dbg_wr_ack;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_done;
    logic        pipe_stall;
    logic [4:0]  dump_raddr;
    logic [31:0] rf_rdata1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    logic [31:0] mem [32] = '{default: '0};
    logic [4:0]  tb_raddr1;

    int total = 0;
    int bad   = 0;

    always #5 clk_o = ~clk_o;

    assign rf_rdata1 = mem[pipe_stall ? dump_raddr : tb_raddr1];

    always @(posedge clk_o)
        if (rf_we) mem[rf_waddr] <= rf_wdata;

    rf_dbg_ctrl dut (
        .clk_o(clk_o), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .dbg_wr_req(dbg_wr_req), .dbg_waddr(dbg_waddr),
        .dbg_wdata(dbg_wdata), .dbg_wr_ack(dbg_wr_ack),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_done(dump_done), .pipe_stall(pipe_stall),
        .dump_raddr(dump_raddr), .rf_rdata1(rf_rdata1),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk_o);
        dbg_wr_req = 1'b1; dbg_waddr = a; dbg_wdata = d;
        #1;
        while (!dbg_wr_ack && n < 20) begin
            @(negedge clk_o); #1; n++;
        end
        chk("preload_ack", dbg_wr_ack, 1);
        @(negedge clk_o);
        dbg_wr_req = 1'b0;
    endtask

    task automatic run_dump(input int stall_at, input int stall_len,
                            input bit rnd, input int abort_at,
                            input bit chk_cyc, input bit wb_poke,
                            input bit dbg_hold);
        logic [7:0]  exp_q [$];
        logic [7:0]  ck = '0;
        logic [31:0] w;
        logic [7:0]  b;
        int nb = 0, cyc = 0, stall_left = 0;
        bit stalled = 0, done = 0;
        for (int i = 0; i < N; i++) begin
            w = (i == 0) ? 32'h0 : mem[i];
            for (int k = NB - 1; k >= 0; k--) begin
                b = 8'(w >> (8 * k));
                exp_q.push_back(b);
                ck ^= b;
            end
        end
        if (CK == 1) exp_q.push_back(ck);

        @(negedge clk_o);
        dump_start = 1'b1; tx_ready = 1'b1;
        #1;
        chk("start_idle", dump_busy, 0);
        while (!done) begin
            @(negedge clk_o);
            dump_start = 1'b0;
            cyc++;
            if (wb_poke && cyc == 1) begin
                wb_we = 1'b1; wb_waddr = 5'd20; wb_wdata = 32'hCAFE0020;
            end else begin
                wb_we = 1'b0;
            end
            if (dbg_hold && cyc == 1) begin
                dbg_wr_req = 1'b1; dbg_waddr = 5'd7; dbg_wdata = 32'hA5A50007;
            end
            #1;
            chk("stall_hi", pipe_stall, 1);
            chk("busy_hi", dump_busy, 1);
            if (wb_poke && cyc == 1) begin
                chk("wb_in_dump_we", rf_we, 1);
                chk("wb_in_dump_addr", rf_waddr, 20);
                chk("wb_in_dump_data", rf_wdata, 32'hCAFE0020);
            end
            if (dbg_hold) chk("dbg_blocked", dbg_wr_ack, 0);
            if (abort_at >= 0 && tx_valid && nb == abort_at) begin
                rst = 1'b1;
                @(posedge clk_o); #1;
                chk("abort_valid", tx_valid, 0);
                chk("abort_stall", pipe_stall, 0);
                chk("abort_busy", dump_busy, 0);
                chk("abort_done", dump_done, 0);
                @(negedge clk_o);
                rst = 1'b0;
                return;
            end
            if (stall_left > 0) chk("hold_valid", tx_valid, 1);
            if (!stalled && stall_at >= 0 && tx_valid && nb == stall_at) begin
                stalled = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (tx_valid) begin
                if (nb < exp_q.size()) chk("tx_byte", tx_data, exp_q[nb]);
                else chk("extra_byte", nb, exp_q.size());
                if (tx_ready) nb++;
            end
            if (dump_done) begin
                done = 1;
                chk("byte_count", nb, exp_q.size());
                if (chk_cyc)
                    chk("done_cyc", cyc,
                        DRAIN + (NB + 1) * N + 1 + CK + stall_len);
            end
            if (cyc > 3000) begin
                chk("dump_timeout", 0, 1);
                done = 1;
            end
        end
        @(negedge clk_o);
        tx_ready = 1'b1;
        #1;
        chk("after_busy", dump_busy, 0);
        chk("after_done", dump_done, 0);
        if (dbg_hold) begin
            chk("dbg_late_ack", dbg_wr_ack, 1);
            chk("dbg_late_we", rf_we, 1);
            chk("dbg_late_addr", rf_waddr, 7);
            @(negedge clk_o);
            dbg_wr_req = 1'b0;
        end
    endtask

    initial begin
        logic        exp_we, exp_ack;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        bit          pend;

        rst = 1'b1; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        dbg_wr_req = 0; dbg_waddr = 0; dbg_wdata = 0;
        dump_start = 0; tx_ready = 1; tb_raddr1 = 0;
        repeat (3) @(negedge clk_o);
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_ack", dbg_wr_ack, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_raddr", dump_raddr, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        @(negedge clk_o);
        rst = 1'b0;

        // writeback and debug collide: writeback first, debug next cycle
        @(negedge clk_o);
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
        dbg_wr_req = 1; dbg_waddr = 6; dbg_wdata = 32'h12345678;
        #1;
        chk("arb_wb_we", rf_we, 1);
        chk("arb_wb_addr", rf_waddr, 5);
        chk("arb_wb_data", rf_wdata, 32'hDEADBEEF);
        chk("arb_wb_ack", dbg_wr_ack, 0);
        @(negedge clk_o);
        wb_we = 0;
        #1;
        chk("arb_dbg_we", rf_we, 1);
        chk("arb_dbg_addr", rf_waddr, 6);
        chk("arb_dbg_data", rf_wdata, 32'h12345678);
        chk("arb_dbg_ack", dbg_wr_ack, 1);
        @(negedge clk_o);
        dbg_wr_req = 0; tb_raddr1 = 5;
        #1;
        chk("arb_quiet_ack", dbg_wr_ack, 0);
        chk("x5_rd", rf_rdata1, 32'hDEADBEEF);

        // debug write to x0 is acked but never reaches the file
        @(negedge clk_o);
        dbg_wr_req = 1; dbg_waddr = 0; dbg_wdata = 32'hFFFFFFFF;
        #1;
        chk("x0_ack", dbg_wr_ack, 1);
        chk("x0_we", rf_we, 0);
        @(negedge clk_o);
        dbg_wr_req = 0; tb_raddr1 = 0;
        #1;
        chk("x0_rd", rf_rdata1, 0);

        // random arbitration traffic
        pend = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_o);
            wb_we = 1'($urandom_range(0, 1));
            wb_waddr = 5'($urandom_range(1, 31));
            wb_wdata = $urandom;
            if (!pend) begin
                dbg_wr_req = 1'($urandom_range(0, 1));
                dbg_waddr = 5'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
            #1;
            exp_we = 0; exp_ack = 0; exp_a = 0; exp_d = 0;
            if (wb_we) begin
                exp_we = 1; exp_a = wb_waddr; exp_d = wb_wdata;
            end else if (dbg_wr_req) begin
                exp_ack = 1; exp_we = (dbg_waddr != 0);
                exp_a = dbg_waddr; exp_d = dbg_wdata;
            end
            chk("rnd_ack", dbg_wr_ack, exp_ack);
            chk("rnd_we", rf_we, exp_we);
            if (exp_we) begin
                chk("rnd_addr", rf_waddr, exp_a);
                chk("rnd_data", rf_wdata, exp_d);
            end
            pend = dbg_wr_req && !exp_ack;
        end
        @(negedge clk_o);
        wb_we = 0; dbg_wr_req = 0;

        for (int i = 1; i < N; i++) dbg_write(5'(i), 32'(i) * 32'h01010101);

        run_dump(-1, 0, 0, -1, 1, 0, 0);
        run_dump(14, 10, 0, -1, 1, 0, 0);
        run_dump(-1, 0, 0, 40, 0, 1, 0);
        run_dump(-1, 0, 1, -1, 0, 0, 1);

        for (int i = 0; i < 8; i++)
            dbg_write(5'($urandom_range(1, 31)), $urandom);
        run_dump(-1, 0, 1, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
